// File: rtl/mdu_ctrl_pkg.sv
// Shared opcodes, sequencer states and opcode-class helpers for the
// multiply/divide unit.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2
  } mds_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the
// current operands plus a flag marking a divide by zero.
module md_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [63:0] res,
  output logic        divZero
);

  logic        b_zero;
  logic        s_ovf;
  logic [31:0] s_divisor;
  logic [31:0] u_divisor;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;
  logic [31:0] u_quo;
  logic [31:0] u_rem;
  logic signed [63:0] s_prod;
  logic [63:0] u_prod;

  assign b_zero = (srcB == 32'd0);
  // 0x80000000 / -1 overflows; dividing by 1 instead yields exactly the
  // wanted quotient 0x80000000 and remainder 0.
  assign s_ovf     = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
  // Divisors are forced nonzero so the dividers never see a zero operand;
  // the divZero flag makes the sequencer discard that result anyway.
  assign s_divisor = (b_zero || s_ovf) ? 32'd1 : srcB;
  assign u_divisor = b_zero ? 32'd1 : srcB;

  assign s_quo  = $signed(srcA) / $signed(s_divisor);
  assign s_rem  = $signed(srcA) % $signed(s_divisor);
  assign u_quo  = srcA / u_divisor;
  assign u_rem  = srcA % u_divisor;
  assign s_prod = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign u_prod = {32'd0, srcA} * {32'd0, srcB};

  // Select the result for the requested operation; {hi, lo} layout.
  always_comb begin
    res     = 64'd0;
    divZero = 1'b0;
    case (mdOp)
      MD_MULT:  res = s_prod;
      MD_MULTU: res = u_prod;
      MD_DIV: begin
        res     = {s_rem, s_quo};
        divZero = b_zero;
      end
      MD_DIVU: begin
        res     = {u_rem, u_quo};
        divZero = b_zero;
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is
// captured on the start edge and committed after a fixed busy latency.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] mdRes,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a one-cycle request qualified by mdOp; it is
  // accepted only on an edge where busy is low (busy acts as not-ready).
  // A start seen while busy, or with a non-mult/div mdOp, is dropped.
  // busy rises on the accepting edge and falls on the commit edge.

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

  mds_e        state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [63:0] calc_res;
  logic        calc_dz;

  md_calc u_calc (
    .mdOp    (mdOp),
    .srcA    (srcA),
    .srcB    (srcB),
    .res     (calc_res),
    .divZero (calc_dz)
  );

  assign dbg_state = state;

  // Sequencer: accept starts, count down the latency, commit HI/LO, serve MT writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MDS_IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
    end else begin
      case (state)
        MDS_IDLE: begin
          if (start && is_mul(mdOp)) begin
            state              <= MDS_MUL;
            cnt                <= MUL_LAST;
            busy               <= 1'b1;
            {pend_hi, pend_lo} <= calc_res;
            pend_dz            <= calc_dz;
          end else if (start && is_div(mdOp)) begin
            state              <= MDS_DIV;
            cnt                <= DIV_LAST;
            busy               <= 1'b1;
            {pend_hi, pend_lo} <= calc_res;
            pend_dz            <= calc_dz;
          end else if (!start && (mdOp == MD_MTHI)) begin
            hi <= srcA;
          end else if (!start && (mdOp == MD_MTLO)) begin
            lo <= srcA;
          end
        end
        default: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= MDS_IDLE;
            busy  <= 1'b0;
            // A divide by zero burns the full latency but leaves HI/LO alone.
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
      endcase
    end
  end

  // Move-from read port: plain view of the architectural HI/LO registers.
  always_comb begin
    mdRes = 32'd0;
    if (mdOp == MD_MFHI)      mdRes = hi;
    else if (mdOp == MD_MFLO) mdRes = lo;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the P6 pipelined MIPS core. Sits in the E stage beside the single-cycle ALU.
- Accepts mult/multu/div/divu starts and holds busy for a fixed latency, then commits HI/LO.
- Serves mthi/mtlo writes and mfhi/mflo reads.
- The hazard unit stalls D-stage MD instructions using start | busy.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage instruction is mult/multu/div/divu; qualifies mdOp.
- mdOp  input  4  operation code (see package constants).
- srcA  input  32  rs operand, forwarded.
- srcB  input  32  rt operand, forwarded.
- busy  output  1  registered; high while a mult/div is in flight.
- mdRes  output  32  combinational: HI when mdOp==MD_MFHI, LO when mdOp==MD_MFLO, else 0.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset, asynchronous: state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0. Takes effect immediately mid-operation; the in-flight result is discarded.
- States:
  - IDLE: start & MULT/MULTU -> MUL, cnt=MUL_CYCLES-1. start & DIV/DIVU -> DIV, cnt=DIV_CYCLES-1.
  - MUL/DIV: cnt!=0 -> decrement. cnt==0 -> commit pending to hi/lo, go to IDLE.
  - busy=1 exactly when state!=IDLE.
- Latency: busy is high for exactly N cycles after the start edge, where N=MUL_CYCLES or DIV_CYCLES. HI/LO update on the edge that ends the N-th busy cycle; mfhi/mflo in the next cycle read the new value.
- Results are computed at the start edge into pendHi/pendLo, so later srcA/srcB changes do not affect them:
  - MULT: signed 32x32 -> 64-bit product; hi=[63:32], lo=[31:0].
  - MULTU: the same, unsigned.
  - DIV: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the dividend's sign. 0x80000000/-1 gives lo=0x80000000, hi=0.
  - DIVU: the same, unsigned.
  - Divide by zero: the full DIV_CYCLES latency is still consumed; hi and lo are left unchanged at commit.
- MTHI/MTLO: in IDLE with start=0, hi (or lo)=srcA on that edge. Ignored while busy, since the hazard unit guarantees this does not occur.
- Any start while busy is ignored and does not restart the operation. Start with a non-mult/div mdOp is ignored.
- mdRes reads the current hi/lo registers and does no forwarding from pending results. Reads during busy return the old value, since the hazard unit stalls them.
- Simultaneous commit edge and MTHI/MTLO: cannot occur, because MT is ignored while busy; the commit wins.
- busy is never combinationally driven from start.

Decomposition:
- Add to macro.v: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8, plus the state encodings MDS_IDLE, MDS_MUL, MDS_DIV.
- One combinational sub-module, md_calc: it takes mdOp, srcA and srcB and produces the 64-bit {pendHi, pendLo} plus a divZero flag.
- The sequencer, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- MULT srcA=0xFFFFFFFE (-2), srcB=3, start 1 cycle -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; mfhi/mflo match on the next cycle.
- DIVU srcA=100, srcB=7 -> busy 10 cycles, then lo=14, hi=2. DIV srcA=-7, srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV by zero with hi=0x11, lo=0x22 preset by MTHI/MTLO -> busy 10 cycles; hi=0x11 and lo=0x22 remain.
- Start MULTU (0xFFFFFFFF * 0xFFFFFFFF), then change srcA/srcB and pulse start again during busy -> the second start is ignored; hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- Assert reset asynchronously (between edges) in cycle 3 of a DIV -> busy, hi and lo go to 0 immediately without waiting for a clock edge. A following MTLO 0x1234 -> lo=0x1234.
- MTHI 0xABCD in IDLE, then mdOp=MD_MFHI -> mdRes=0xABCD. mdOp=MD_MFLO -> mdRes=lo. Other ops -> mdRes=0.
